relu_stream_arbiter: RTL and testbench

- Shares one activation (ReLu) pipeline between NUM_CH convolution output streams at packet (line) granularity.
- Round-robin grant on sop. The grant is held until the granted channel's eop beat is accepted.
- The forwarded stream is registered, with framing (sop/eop/sof/eof) and a source-channel tag.
- Sits between the per-channel conv accumulators and the shared ReLu input.

---
 rtl/relu_stream_arbiter.sv | 178 +++++++++++++++++
 tb/tb_relu_stream_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream_arbiter.sv
// relu_stream_arbiter: packet-granular round-robin mux that shares one ReLu
// pipeline between NUM_CH convolution output streams. The grant is taken on a
// sop request and held until the granted channel's eop beat is accepted. The
// forwarded beat sits in a single output register with its framing and tag.
module relu_stream_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_CH-1:0]            valid_i,
  input  logic [NUM_CH-1:0]            sop_i,
  input  logic [NUM_CH-1:0]            eop_i,
  input  logic [NUM_CH-1:0]            sof_i,
  input  logic [NUM_CH-1:0]            eof_i,
  output logic [NUM_CH-1:0]            ready_o,
  input  logic                         ready_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o,
  output logic [CH_W-1:0]              ch_o,
  output logic                         busy_o,
  output logic                         err_o
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         gnt_q, gnt_d;
  logic [CH_W-1:0]         ptr_q, ptr_d;
  logic                    first_q, first_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    sop_q, sop_d;
  logic                    eop_q, eop_d;
  logic                    sof_q, sof_d;
  logic                    eof_q, eof_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   ch_data [NUM_CH];
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       ready_int;
  logic                    out_free;
  logic [CH_W:0]           pick;
  logic                    accept;

  // First requesting channel at or after p (wrapping); MSB flags "found".
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] r,
                                            input logic [CH_W-1:0]   p);
    logic [CH_W:0]   res;
    logic [CH_W-1:0] idx;
    res = '0;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(p) + i) % NUM_CH);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Wrap-around successor of a channel index.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  // The output register can take a new beat when empty or being drained.
  assign out_free = ~valid_q | ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]   = data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req[gi]       = valid_i[gi] & sop_i[gi];
      assign ready_int[gi] = (state_q == LOCK) && (gnt_q == CH_W'(gi)) && out_free;
      // Held low during reset so no source believes a beat was taken.
      assign ready_o[gi]   = ready_int[gi] & reset_n;
    end
  endgenerate

  assign pick   = rr_pick(req, ptr_q);
  assign accept = valid_i[gnt_q] & ready_int[gnt_q];

  // Next-state logic: arbitration in IDLE, beat transfer and release in LOCK.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    ch_d    = ch_q;
    err_d   = 1'b0;

    // Downstream took the held beat and nothing replaces it.
    if (ready_i) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick[CH_W]) begin
          gnt_d   = pick[CH_W-1:0];
          state_d = LOCK;
          first_d = 1'b1;
        end
      end
      LOCK: begin
        if (accept) begin
          valid_d = 1'b1;
          data_d  = ch_data[gnt_q];
          sop_d   = sop_i[gnt_q];
          eop_d   = eop_i[gnt_q];
          sof_d   = sof_i[gnt_q];
          eof_d   = eof_i[gnt_q];
          ch_d    = gnt_q;
          // A sop after the grant's first beat is a framing violation.
          err_d   = sop_i[gnt_q] & ~first_q;
          first_d = 1'b0;
          if (eop_i[gnt_q]) begin
            state_d = IDLE;
            ptr_d   = next_ch(gnt_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;
  assign ch_o    = ch_q;
  assign busy_o  = (state_q == LOCK);
  assign err_o   = err_q;

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// Bench for relu_stream_arbiter: queue-fed sources, a packet-level reference
// model, directed scenarios with literal expectations, then a random soak.
module tb_relu_stream_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int CH_W   = 2;

  logic                   clk;
  logic                   reset_n;
  logic [NUM_CH*DW-1:0]   data_i;
  logic [NUM_CH-1:0]      valid_i, sop_i, eop_i, sof_i, eof_i, ready_o;
  logic                   ready_i;
  logic [DW-1:0]          data_o;
  logic                   valid_o, sop_o, eop_o, sof_o, eof_o;
  logic [CH_W-1:0]        ch_o;
  logic                   busy_o, err_o;

  relu_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CH_W(CH_W)) dut (
    .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .ready_o(ready_o), .ready_i(ready_i), .data_o(data_o), .valid_o(valid_o),
    .sop_o(sop_o), .eop_o(eop_o), .sof_o(sof_o), .eof_o(eof_o),
    .ch_o(ch_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic sop, eop, sof, eof; } beat_t;
  typedef struct { int ch; logic [7:0] d; logic sop, eop, sof, eof; } obeat_t;

  beat_t  srcq [NUM_CH][$];
  obeat_t olog[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs
  bit          use_pat;
  logic [63:0] rdy_pat;
  int          ready_pct, valid_pct;
  int          tstep;

  // Reference model: packet grant, rr pointer, output beat register
  bit         m_busy, m_first, m_valid, m_err, m_check_all;
  int         m_gnt, m_ptr, m_ch;
  logic [7:0] m_data;
  logic       m_sop, m_eop, m_sof, m_eof;

  // Per-step trace of DUT outputs for the literal scenario checks
  logic             tr_valid [256];
  logic             tr_busy  [256];
  logic             tr_err   [256];
  logic             tr_sop   [256];
  logic             tr_eop   [256];
  logic [7:0]       tr_data  [256];
  int               tr_ch    [256];
  logic [NUM_CH-1:0] tr_rdy  [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic push_pkt(input int k, input int len, input logic [7:0] base,
                          input bit sof, input bit eof, input int mid_sop);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = base + 8'(i);
      b.sop = (i == 0) || (i == mid_sop);
      b.eop = (i == len - 1);
      b.sof = sof && (i == 0);
      b.eof = eof && (i == len - 1);
      srcq[k].push_back(b);
    end
  endtask

  // One clock: check registered outputs, drive inputs, check ready, advance model.
  task automatic step(input bit rst_n);
    logic [NUM_CH-1:0] er;
    logic [NUM_CH-1:0] req;
    beat_t b;
    bit acc;
    @(negedge clk);
    if (tstep < 256) begin
      tr_valid[tstep] = valid_o; tr_busy[tstep] = busy_o; tr_err[tstep] = err_o;
      tr_sop[tstep] = sop_o; tr_eop[tstep] = eop_o; tr_data[tstep] = data_o;
      tr_ch[tstep] = int'(ch_o);
    end
    chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
    chk("busy_o", {31'd0, busy_o}, {31'd0, m_busy});
    chk("err_o", {31'd0, err_o}, {31'd0, m_err});
    if (m_valid || m_check_all) begin
      chk("data_o", {24'd0, data_o}, {24'd0, m_data});
      chk("framing", {28'd0, sop_o, eop_o, sof_o, eof_o}, {28'd0, m_sop, m_eop, m_sof, m_eof});
      chk("ch_o", {30'd0, ch_o}, 32'(m_ch));
    end
    m_check_all = 0;

    reset_n = rst_n;
    ready_i = use_pat ? rdy_pat[tstep % 64] : ($urandom_range(99) < ready_pct);
    for (int k = 0; k < NUM_CH; k++) begin
      if (srcq[k].size() > 0 && $urandom_range(99) < valid_pct) begin
        b = srcq[k][0];
        valid_i[k] = 1'b1;
        data_i[k*DW +: DW] = b.d;
        sop_i[k] = b.sop; eop_i[k] = b.eop; sof_i[k] = b.sof; eof_i[k] = b.eof;
      end else begin
        valid_i[k] = 1'b0;
        data_i[k*DW +: DW] = 8'($urandom);
        sop_i[k] = 1'($urandom); eop_i[k] = 1'($urandom);
        sof_i[k] = 1'($urandom); eof_i[k] = 1'($urandom);
      end
    end
    #1;
    er = '0;
    if (rst_n && m_busy) er[m_gnt] = !m_valid || ready_i;
    chk("ready_o", {28'd0, ready_o}, {28'd0, er});
    if (tstep < 256) tr_rdy[tstep] = ready_o;
    if (valid_o && ready_i)
      olog.push_back('{int'(ch_o), data_o, sop_o, eop_o, sof_o, eof_o});

    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) srcq[k].delete();
      m_busy = 0; m_first = 0; m_valid = 0; m_err = 0; m_gnt = 0; m_ptr = 0;
      m_ch = 0; m_data = '0; m_sop = 0; m_eop = 0; m_sof = 0; m_eof = 0;
      m_check_all = 1;
    end else if (!m_busy) begin
      m_err = 0;
      if (ready_i) m_valid = 0;
      req = valid_i & sop_i;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!m_busy && req[(m_ptr + i) % NUM_CH]) begin
          m_busy = 1; m_first = 1; m_gnt = (m_ptr + i) % NUM_CH;
        end
      end
    end else begin
      acc = valid_i[m_gnt] && er[m_gnt];
      m_err = 0;
      if (acc) begin
        b = srcq[m_gnt].pop_front();
        m_valid = 1; m_data = b.d; m_sop = b.sop; m_eop = b.eop;
        m_sof = b.sof; m_eof = b.eof; m_ch = m_gnt;
        m_err = b.sop && !m_first;
        m_first = 0;
        if (b.eop) begin
          m_busy = 0;
          m_ptr = (m_gnt + 1) % NUM_CH;
        end
      end else if (ready_i) begin
        m_valid = 0;
      end
    end
    tstep++;
  endtask

  task automatic do_reset();
    use_pat = 1; rdy_pat = '1; valid_pct = 100; ready_pct = 100;
    step(1'b0);
    tstep = 0;
    olog.delete();
  endtask

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int errs;

  initial begin
    reset_n = 1'b0; ready_i = 1'b0; data_i = '0; valid_i = '0;
    sop_i = '0; eop_i = '0; sof_i = '0; eof_i = '0;
    tstep = 0; use_pat = 1; rdy_pat = '1; valid_pct = 100; ready_pct = 100;
    m_busy = 0; m_first = 0; m_valid = 0; m_err = 0; m_gnt = 0; m_ptr = 0;
    m_ch = 0; m_data = '0; m_sop = 0; m_eop = 0; m_sof = 0; m_eof = 0; m_check_all = 1;
    @(posedge clk);

    // Single channel 4-beat packet on ch2
    do_reset();
    chk("rst_valid", {31'd0, tr_valid[0]}, 32'd0);
    chk("rst_busy", {31'd0, tr_busy[0]}, 32'd0);
    push_pkt(2, 4, 8'h20, 0, 0, -1);
    for (int s = 0; s < 10; s++) step(1'b1);
    chk("t1_busy_after_grant", {31'd0, tr_busy[1]}, 32'd1);
    chk("t1_valid_before", {31'd0, tr_valid[1]}, 32'd0);
    for (int s = 2; s <= 5; s++) chk("t1_valid_run", {31'd0, tr_valid[s]}, 32'd1);
    chk("t1_valid_after", {31'd0, tr_valid[6]}, 32'd0);
    chk("t1_ch", 32'(tr_ch[2]), 32'd2);
    chk("t1_sop_first", {31'd0, tr_sop[2]}, 32'd1);
    chk("t1_eop_last", {31'd0, tr_eop[5]}, 32'd1);
    chk("t1_busy_held", {31'd0, tr_busy[4]}, 32'd1);
    chk("t1_busy_fall", {31'd0, tr_busy[5]}, 32'd0);
    chk("t1_count", 32'(olog.size()), 32'd4);

    // Round-robin with all channels requesting back-to-back 2-beat packets
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NUM_CH; k++) push_pkt(k, 2, 8'(16 * k + 4 * r), 0, 0, -1);
    for (int s = 0; s < 30; s++) step(1'b1);
    chk("t2_count", 32'(olog.size()), 32'd16);
    for (int i = 0; i < 16 && i < olog.size(); i += 2)
      chk("t2_order", 32'(olog[i].ch), 32'(exp_order[i / 2]));
    chk("t2_bubble", {31'd0, tr_valid[4]}, 32'd0);
    chk("t2_next_pkt", {31'd0, tr_valid[5]}, 32'd1);

    // Backpressure on ch1 3-beat packet
    do_reset();
    rdy_pat = ~64'h1C;
    push_pkt(1, 3, 8'hA0, 0, 0, -1);
    for (int s = 0; s < 12; s++) step(1'b1);
    for (int s = 2; s <= 4; s++) begin
      chk("t3_hold_data", {24'd0, tr_data[s]}, 32'hA0);
      chk("t3_hold_sop", {31'd0, tr_sop[s]}, 32'd1);
      chk("t3_hold_ch", 32'(tr_ch[s]), 32'd1);
      chk("t3_stall_ready", {28'd0, tr_rdy[s]}, 32'd0);
    end
    chk("t3_count", 32'(olog.size()), 32'd3);
    for (int i = 0; i < 3 && i < olog.size(); i++)
      chk("t3_order", {24'd0, olog[i].d}, 32'hA0 + 32'(i));

    // Single-beat packets with frame markers on ch0
    do_reset();
    push_pkt(0, 1, 8'h55, 1, 0, -1);
    push_pkt(0, 1, 8'h66, 0, 1, -1);
    for (int s = 0; s < 10; s++) step(1'b1);
    chk("t4_count", 32'(olog.size()), 32'd2);
    if (olog.size() >= 2) begin
      chk("t4_b0", {24'd0, olog[0].d, 4'd0, olog[0].sop, olog[0].eop, olog[0].sof, olog[0].eof},
          {24'd0, 8'h55, 8'b0000_1110});
      chk("t4_b1", {24'd0, olog[1].d, 4'd0, olog[1].sop, olog[1].eop, olog[1].sof, olog[1].eof},
          {24'd0, 8'h66, 8'b0000_1101});
    end

    // Protocol error: sop reasserted on beat 2 of a ch3 packet
    do_reset();
    push_pkt(3, 4, 8'hC0, 0, 0, 2);
    for (int s = 0; s < 12; s++) step(1'b1);
    errs = 0;
    for (int s = 0; s < 12; s++) errs += int'(tr_err[s]);
    chk("t5_err_pulses", 32'(errs), 32'd1);
    chk("t5_err_time", {31'd0, tr_err[4]}, 32'd1);
    chk("t5_err_beat", {24'd0, tr_data[4]}, 32'hC2);
    chk("t5_err_sop", {31'd0, tr_sop[4]}, 32'd1);
    chk("t5_grant_held", {31'd0, tr_busy[4]}, 32'd1);
    chk("t5_count", 32'(olog.size()), 32'd4);

    // Reset in the middle of a ch1 packet after ch0 moved the pointer
    do_reset();
    push_pkt(0, 1, 8'h01, 0, 0, -1);
    push_pkt(1, 5, 8'h10, 0, 0, -1);
    for (int s = 0; s < 7; s++) step(s == 5 ? 1'b0 : 1'b1);
    chk("t6_valid", {31'd0, tr_valid[6]}, 32'd0);
    chk("t6_busy", {31'd0, tr_busy[6]}, 32'd0);
    chk("t6_ready", {28'd0, tr_rdy[6]}, 32'd0);
    olog.delete();
    push_pkt(0, 1, 8'h77, 0, 0, -1);
    push_pkt(1, 1, 8'h88, 0, 0, -1);
    for (int s = 0; s < 8; s++) step(1'b1);
    chk("t6_count", 32'(olog.size()), 32'd2);
    if (olog.size() >= 2) begin
      chk("t6_first_ch", 32'(olog[0].ch), 32'd0);
      chk("t6_second_ch", 32'(olog[1].ch), 32'd1);
    end

    // Random soak against the model
    use_pat = 0;
    for (int it = 0; it < 4000; it++) begin
      if (it % 500 == 0) begin
        ready_pct = (it % 1500 == 0) ? 100 : ((it % 1000 == 0) ? 30 : 70);
        valid_pct = (it % 1000 == 500) ? 60 : 100;
      end
      for (int k = 0; k < NUM_CH; k++)
        if (srcq[k].size() == 0 && $urandom_range(99) < 30) begin
          int len;
          len = int'($urandom_range(5, 1));
          push_pkt(k, len, 8'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(9) == 0 && len > 1) ? int'($urandom_range(len - 1, 1)) : -1);
        end
      step(($urandom_range(499) == 0) ? 1'b0 : 1'b1);
    end
    for (int s = 0; s < 5; s++) step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
